// File: rtl/qmax_update_table.sv
// qmax_update_table: per-state Q-max store with a read-compare-write update port.
//
// Handshake: there is no backpressure. A request (i_rd_en or i_upd_en) is
// taken at a rising edge only when o_ready is 1 at that edge. A taken read
// answers with a one-cycle o_rd_valid pulse one cycle later. A taken update
// answers with a one-cycle o_upd_done pulse two cycles later. A request made
// while o_ready is 0 is dropped without any trace.
//
// Only two writers touch the memory: the clear sweep, while in CLEAR, and the
// S2 commit, while in RUN. They can never collide.
module qmax_update_table #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter bit                    SIGNED     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  output logic                  o_ready,
  output logic                  o_busy,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_addr_r,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  input  logic                  i_upd_en,
  input  logic                  i_upd_mode,
  input  logic [ADDR_WIDTH-1:0] i_addr_w,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_upd_done,
  output logic                  o_upd_changed,
  output logic [0:0]            o_fsm_state
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // S1 holds an accepted update. It commits on the next edge, which is "S2".
  logic                  s1_valid;
  logic                  s1_mode;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_old;

  logic                  rd_accept;
  logic                  upd_accept;
  logic                  s1_gt;
  logic                  commit_we;
  logic [DATA_WIDTH-1:0] new_val;
  logic [DATA_WIDTH-1:0] rd_fwd;
  logic [DATA_WIDTH-1:0] upd_old;

  assign o_ready     = (state == ST_RUN);
  assign o_busy      = ~o_ready;
  assign o_fsm_state = state;
  assign rd_accept   = i_rd_en & o_ready;
  // An update is not taken on the edge that starts a clear. Otherwise its
  // commit would land inside the sweep and could leave a stale entry behind.
  assign upd_accept  = i_upd_en & o_ready & ~i_clear;

  // Work out the S2 result, and forward the committing write to both lookups.
  always_comb begin
    s1_gt     = SIGNED ? ($signed(s1_data) > $signed(s1_old)) : (s1_data > s1_old);
    new_val   = s1_mode ? s1_data : (s1_gt ? s1_data : s1_old);
    commit_we = s1_valid && (new_val != s1_old);
    rd_fwd    = (commit_we && (s1_addr == i_addr_r)) ? new_val : mem[i_addr_r];
    upd_old   = (commit_we && (s1_addr == i_addr_w)) ? new_val : mem[i_addr_w];
  end

  // Control FSM: the clear sweep pointer, and the CLEAR/RUN sequencing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (i_clear) begin
            clr_ptr <= '0;
          end else if (clr_ptr == LAST_ADDR) begin
            clr_ptr <= '0;
            state   <= ST_RUN;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          if (i_clear) begin
            clr_ptr <= '0;
            state   <= ST_CLEAR;
          end
        end
      endcase
    end
  end

  // Memory array: sweep writes in CLEAR, S2 commits in RUN. There is no reset.
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= INIT_VAL;
    end else if (commit_we) begin
      mem[s1_addr] <= new_val;
    end
  end

  // Update pipeline: S1 capture with forwarded old value, and S2 retire flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid      <= 1'b0;
      s1_mode       <= 1'b0;
      s1_addr       <= '0;
      s1_data       <= '0;
      s1_old        <= '0;
      o_upd_done    <= 1'b0;
      o_upd_changed <= 1'b0;
    end else begin
      s1_valid      <= upd_accept;
      o_upd_done    <= s1_valid;
      o_upd_changed <= commit_we;
      if (upd_accept) begin
        s1_mode <= i_upd_mode;
        s1_addr <= i_addr_w;
        s1_data <= i_data;
        s1_old  <= upd_old;
      end
    end
  end

  // Read port: write-first against S2, and o_data holds between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data     <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= rd_accept;
      if (rd_accept) begin
        o_data <= rd_fwd;
      end
    end
  end

endmodule

// File: tb/tb_qmax_update_table.sv
// tb_qmax_update_table: directed scoreboard bench for qmax_update_table.
module tb_qmax_update_table;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_ready;
  logic        o_busy;
  logic        i_rd_en = 1'b0;
  logic [5:0]  i_addr_r = '0;
  logic [31:0] o_data;
  logic        o_rd_valid;
  logic        i_upd_en = 1'b0;
  logic        i_upd_mode = 1'b0;
  logic [5:0]  i_addr_w = '0;
  logic [31:0] i_data = '0;
  logic        o_upd_done;
  logic        o_upd_changed;
  logic [0:0]  o_fsm_state;

  int checks = 0;
  int failures = 0;
  int cycles;
  logic [31:0] rd_exp_q[$];
  logic [31:0] upd_exp_q[$];

  qmax_update_table dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .o_ready(o_ready), .o_busy(o_busy),
    .i_rd_en(i_rd_en), .i_addr_r(i_addr_r), .o_data(o_data), .o_rd_valid(o_rd_valid),
    .i_upd_en(i_upd_en), .i_upd_mode(i_upd_mode), .i_addr_w(i_addr_w), .i_data(i_data),
    .o_upd_done(o_upd_done), .o_upd_changed(o_upd_changed), .o_fsm_state(o_fsm_state)
  );

  // Clock and reset block
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge. It applies one cycle of requests and returns at the next negedge.
  task automatic drive(input logic rd, input logic [5:0] ra, input logic upd,
                       input logic mode, input logic [5:0] wa, input logic [31:0] wd);
    i_rd_en = rd; i_addr_r = ra;
    i_upd_en = upd; i_upd_mode = mode; i_addr_w = wa; i_data = wd;
    @(negedge i_clk);
    i_rd_en = 1'b0; i_upd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Counts the edges until o_ready rises, with a bound on the wait.
  task automatic wait_ready(input string tag);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge i_clk);
      cycles++;
      #1;
      if (o_ready) break;
    end
    chk(tag, cycles, 64);
  endtask

  // Scoreboard: outputs are popped and compared on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rd_valid) begin
        if (rd_exp_q.size() == 0) chk("rd_unexpected_pulse", {31'd0, o_rd_valid}, 32'd0);
        else chk("rd_data", o_data, rd_exp_q.pop_front());
      end
      if (o_upd_done) begin
        if (upd_exp_q.size() == 0) chk("upd_unexpected_pulse", {31'd0, o_upd_done}, 32'd0);
        else chk("upd_changed", {31'd0, o_upd_changed}, upd_exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_upd_done", {31'd0, o_upd_done}, 32'd0);
    chk("rst_upd_changed", {31'd0, o_upd_changed}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    // Requests made during the initial sweep must be dropped
    i_rd_en = 1'b1; i_upd_en = 1'b1; i_upd_mode = 1'b1; i_addr_w = 6'd33; i_data = 32'd1234;
    i_rst_n = 1'b1;
    wait_ready("ready_low_after_reset");
    i_rd_en = 1'b0; i_upd_en = 1'b0;
    @(negedge i_clk);
    chk("fsm_state_run", {31'd0, o_fsm_state}, 32'd1);
    chk("busy_low_in_run", {31'd0, o_busy}, 32'd0);

    // Read after the initial clear
    rd_exp_q.push_back(32'd0); drive(1, 6'd33, 0, 0, 0, 0);

    // Max mode on entry 5
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 1, 6'd5, 32'd10);
    idle(2);
    upd_exp_q.push_back(32'd0); drive(0, 0, 1, 0, 6'd5, 32'd7);
    idle(2);
    rd_exp_q.push_back(32'd10); drive(1, 6'd5, 0, 0, 0, 0);
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 0, 6'd5, 32'd20);
    idle(2);
    rd_exp_q.push_back(32'd20); drive(1, 6'd5, 0, 0, 0, 0);

    // Signed compare on entry 3
    upd_exp_q.push_back(32'd0); drive(0, 0, 1, 0, 6'd3, 32'hFFFF_FFFC);
    idle(2);
    rd_exp_q.push_back(32'd0); drive(1, 6'd3, 0, 0, 0, 0);
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 1, 6'd3, 32'hFFFF_FFFC);
    idle(2);
    rd_exp_q.push_back(32'hFFFF_FFFC); drive(1, 6'd3, 0, 0, 0, 0);

    // Back-to-back updates to addr 9. The third cycle also reads addr 9 while 50 commits.
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 0, 6'd9, 32'd30);
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 0, 6'd9, 32'd50);
    upd_exp_q.push_back(32'd0); rd_exp_q.push_back(32'd50);
    drive(1, 6'd9, 1, 0, 6'd9, 32'd40);
    idle(2);
    rd_exp_q.push_back(32'd50); drive(1, 6'd9, 0, 0, 0, 0);

    // A read issued with the update request sees the old value
    upd_exp_q.push_back(32'd1); rd_exp_q.push_back(32'd0);
    drive(1, 6'd12, 1, 1, 6'd12, 32'd77);
    idle(2);
    rd_exp_q.push_back(32'd77); drive(1, 6'd12, 0, 0, 0, 0);
    upd_exp_q.push_back(32'd0); drive(0, 0, 1, 0, 6'd12, 32'd77);
    upd_exp_q.push_back(32'd0); drive(0, 0, 1, 1, 6'd12, 32'd77);
    idle(3);

    // Clear while an update sits in S2. Its done pulse still arrives once.
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 1, 6'd20, 32'd99);
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    i_rd_en = 1'b1; i_addr_r = 6'd20; i_upd_en = 1'b1; i_upd_mode = 1'b1;
    i_addr_w = 6'd20; i_data = 32'd5;
    chk("busy_in_clear", {31'd0, o_busy}, 32'd1);
    wait_ready("ready_low_after_clear");
    i_rd_en = 1'b0; i_upd_en = 1'b0;
    @(negedge i_clk);
    for (int a = 0; a < 64; a++) begin
      rd_exp_q.push_back(32'd0);
      drive(1, a[5:0], 0, 0, 0, 0);
    end
    idle(3);
    chk("queues_empty_after_clear", rd_exp_q.size() + upd_exp_q.size(), 32'd0);

    // Reset asserted in the middle of a sweep
    upd_exp_q.push_back(32'd1); drive(0, 0, 1, 1, 6'd7, 32'd55);
    idle(2);
    rd_exp_q.push_back(32'd55); drive(1, 6'd7, 0, 0, 0, 0);
    idle(1);
    i_clear = 1'b1; @(negedge i_clk); i_clear = 1'b0;
    idle($urandom_range(5, 20));
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_o_data", o_data, 32'd0);
    chk("midrst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("midrst_upd_done", {31'd0, o_upd_done}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_ready("ready_low_after_midrst");
    @(negedge i_clk);
    rd_exp_q.push_back(32'd0); drive(1, 6'd7, 0, 0, 0, 0);
    idle(3);
    chk("queues_empty_final", rd_exp_q.size() + upd_exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
